// File: rtl/frame_write_sched_if.sv
// Command, clear and frame-buffer write signals of the text-frame write scheduler.
// The requester side (master) drives commands and the scheduler (slave) drives the frame write port.
interface frame_write_sched_if;
    logic       clear_req;
    logic       clear_busy;

    logic       req0_valid;
    logic       req0_ready;
    logic [5:0] req0_x;
    logic [5:0] req0_y;
    logic [4:0] req0_char;
    logic [5:0] req0_len;

    logic       req1_valid;
    logic       req1_ready;
    logic [5:0] req1_x;
    logic [5:0] req1_y;
    logic [4:0] req1_char;
    logic [5:0] req1_len;

    logic [5:0] fb_x;
    logic [5:0] fb_y;
    logic [4:0] fb_char;
    logic       fb_we;
    logic       err;

    modport master (
        output clear_req,
        input  clear_busy,
        output req0_valid, req0_x, req0_y, req0_char, req0_len,
        input  req0_ready,
        output req1_valid, req1_x, req1_y, req1_char, req1_len,
        input  req1_ready,
        input  fb_x, fb_y, fb_char, fb_we, err
    );

    modport slave (
        input  clear_req,
        output clear_busy,
        input  req0_valid, req0_x, req0_y, req0_char, req0_len,
        output req0_ready,
        input  req1_valid, req1_x, req1_y, req1_char, req1_len,
        output req1_ready,
        output fb_x, fb_y, fb_char, fb_we, err
    );
endinterface

// File: rtl/frame_write_sched.sv
// Arbitrates two run-length character writers and a full-screen clear sweep
// onto the single registered write port of the 40x30 text frame.
module frame_write_sched #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter logic [4:0] CLEAR_CHAR = 5'd0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    frame_write_sched_if.slave   bus
);
    localparam logic [5:0] COLS_W = 6'(COLS);
    localparam logic [5:0] ROWS_W = 6'(ROWS);
    localparam logic [5:0] LAST_X = 6'(COLS - 1);
    localparam logic [5:0] LAST_Y = 6'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t     state;
    logic       rr;
    logic       clear_pending;
    logic [5:0] remaining;

    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       cmd_bad;
    logic [5:0] cmd_x;
    logic [5:0] cmd_y;
    logic [5:0] cmd_len;
    logic [4:0] cmd_char;
    logic       row_end;
    logic       last_cell;
    logic [5:0] next_x;
    logic [5:0] next_y;

    // A pending clear blocks both requesters; otherwise rr breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !clear_pending) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.clear_busy = clear_pending | (state == CLEAR);

    assign accept   = grant0 | grant1;
    assign cmd_x    = grant1 ? bus.req1_x    : bus.req0_x;
    assign cmd_y    = grant1 ? bus.req1_y    : bus.req0_y;
    assign cmd_char = grant1 ? bus.req1_char : bus.req0_char;
    assign cmd_len  = grant1 ? bus.req1_len  : bus.req0_len;
    assign cmd_bad  = (cmd_x >= COLS_W) || (cmd_y >= ROWS_W) || (cmd_len == 6'd0);

    assign row_end   = (bus.fb_x == LAST_X);
    assign last_cell = row_end && (bus.fb_y == LAST_Y);
    assign next_x    = row_end ? 6'd0 : bus.fb_x + 6'd1;
    assign next_y    = row_end ? bus.fb_y + 6'd1 : bus.fb_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr            <= 1'b0;
            clear_pending <= 1'b0;
            remaining     <= 6'd0;
            bus.fb_x      <= 6'd0;
            bus.fb_y      <= 6'd0;
            bus.fb_char   <= 5'd0;
            bus.fb_we     <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            if (bus.clear_req && state != CLEAR) begin
                clear_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // Entering CLEAR already drives the first cell of the sweep.
                    if (clear_pending) begin
                        clear_pending <= 1'b0;
                        state         <= CLEAR;
                        bus.fb_x      <= 6'd0;
                        bus.fb_y      <= 6'd0;
                        bus.fb_char   <= CLEAR_CHAR;
                        bus.fb_we     <= 1'b1;
                    end else if (accept) begin
                        rr <= grant0;
                        if (cmd_bad) begin
                            bus.err <= 1'b1;
                        end else begin
                            bus.fb_x    <= cmd_x;
                            bus.fb_y    <= cmd_y;
                            bus.fb_char <= cmd_char;
                            bus.fb_we   <= 1'b1;
                            remaining   <= cmd_len - 6'd1;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (remaining == 6'd0) begin
                        bus.fb_we <= 1'b0;
                        state     <= IDLE;
                    end else if (last_cell) begin
                        bus.fb_we <= 1'b0;
                        bus.err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        bus.fb_x  <= next_x;
                        bus.fb_y  <= next_y;
                        remaining <= remaining - 6'd1;
                    end
                end
                CLEAR: begin
                    if (last_cell) begin
                        bus.fb_we <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        bus.fb_x <= next_x;
                        bus.fb_y <= next_y;
                    end
                end
                default: begin
                    bus.fb_we <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_write_sched.sv
// Directed-vector bench for frame_write_sched: single runs, row wrap, truncation,
// round-robin arbitration, rejects, clear priority and asynchronous reset.
module tb_frame_write_sched;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    frame_write_sched_if bus ();

    frame_write_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_write(input string tag, input logic [5:0] x, input logic [5:0] y, input logic [4:0] ch);
        check_output(tag, {14'd0, bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_char}, {14'd0, 1'b1, x, y, ch});
    endtask

    task automatic apply_stimulus(input int req, input logic valid, input logic [5:0] x,
                                  input logic [5:0] y, input logic [4:0] ch, input logic [5:0] len);
        if (req == 0) begin
            bus.req0_valid = valid; bus.req0_x = x; bus.req0_y = y;
            bus.req0_char = ch; bus.req0_len = len;
        end else begin
            bus.req1_valid = valid; bus.req1_x = x; bus.req1_y = y;
            bus.req1_char = ch; bus.req1_len = len;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.clear_req = 1'b0;
        apply_stimulus(0, 1'b0, 6'd0, 6'd0, 5'd0, 6'd0);
        apply_stimulus(1, 1'b0, 6'd0, 6'd0, 5'd0, 6'd0);
        tick();
        tick();
        check_output("reset_outputs", {bus.fb_we, bus.err, bus.clear_busy, bus.fb_x, bus.fb_y, bus.fb_char},
                     '0);
        reset_n = 1'b1;
        tick();

        // single command on requester 0
        apply_stimulus(0, 1'b1, 6'd5, 6'd2, 5'd7, 6'd3);
        #1 check_output("single_ready", bus.req0_ready, 1);
        tick();
        check_write("single_cell0", 6'd5, 6'd2, 5'd7);
        check_output("single_ready_run", bus.req0_ready, 0);
        tick();
        check_write("single_cell1", 6'd6, 6'd2, 5'd7);
        tick();
        check_write("single_cell2", 6'd7, 6'd2, 5'd7);
        bus.req0_valid = 1'b0;
        tick();
        check_output("single_end", {bus.fb_we, bus.err}, 0);

        // row wrap on requester 1
        apply_stimulus(1, 1'b1, 6'd38, 6'd10, 5'd3, 6'd4);
        #1 check_output("wrap_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
        tick();
        bus.req1_valid = 1'b0;
        check_write("wrap_cell0", 6'd38, 6'd10, 5'd3);
        tick();
        check_write("wrap_cell1", 6'd39, 6'd10, 5'd3);
        tick();
        check_write("wrap_cell2", 6'd0, 6'd11, 5'd3);
        tick();
        check_write("wrap_cell3", 6'd1, 6'd11, 5'd3);
        tick();
        check_output("wrap_end", {bus.fb_we, bus.err}, 0);

        // truncation at the bottom-right corner
        apply_stimulus(1, 1'b1, 6'd38, 6'd29, 5'd9, 6'd4);
        tick();
        bus.req1_valid = 1'b0;
        check_write("trunc_cell0", 6'd38, 6'd29, 5'd9);
        tick();
        check_write("trunc_cell1", 6'd39, 6'd29, 5'd9);
        check_output("trunc_err_early", bus.err, 0);
        tick();
        check_output("trunc_err_pulse", {bus.fb_we, bus.err}, 2'b01);
        tick();
        check_output("trunc_err_clear", {bus.fb_we, bus.err}, 0);

        // round-robin arbitration from reset
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        apply_stimulus(0, 1'b1, 6'd1, 6'd1, 5'd1, 6'd1);
        apply_stimulus(1, 1'b1, 6'd2, 6'd2, 5'd2, 6'd1);
        #1 check_output("arb_grant0", {bus.req0_ready, bus.req1_ready}, 2'b10);
        tick();
        check_write("arb_write0", 6'd1, 6'd1, 5'd1);
        check_output("arb_run_ready", {bus.req0_ready, bus.req1_ready}, 0);
        tick();
        check_output("arb_idle0", bus.fb_we, 0);
        check_output("arb_grant1", {bus.req0_ready, bus.req1_ready}, 2'b01);
        tick();
        check_write("arb_write1", 6'd2, 6'd2, 5'd2);
        tick();
        check_output("arb_idle1", bus.fb_we, 0);
        check_output("arb_grant2", {bus.req0_ready, bus.req1_ready}, 2'b10);
        tick();
        check_write("arb_write2", 6'd1, 6'd1, 5'd1);
        tick();
        check_output("arb_grant3", {bus.req0_ready, bus.req1_ready}, 2'b01);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // rejects: column out of range, then zero length
        apply_stimulus(0, 1'b1, 6'd40, 6'd0, 5'd5, 6'd2);
        #1 check_output("rej_x_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        check_output("rej_x_err", {bus.fb_we, bus.err}, 2'b01);
        tick();
        check_output("rej_x_after", {bus.fb_we, bus.err}, 0);
        apply_stimulus(0, 1'b1, 6'd0, 6'd0, 5'd5, 6'd0);
        #1 check_output("rej_len_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        check_output("rej_len_err", {bus.fb_we, bus.err}, 2'b01);
        tick();
        check_output("rej_len_after", {bus.fb_we, bus.err}, 0);

        // clear requested mid-run waits for the run, then beats requester 0
        apply_stimulus(0, 1'b1, 6'd0, 6'd5, 5'd4, 6'd10);
        tick();
        apply_stimulus(0, 1'b1, 6'd3, 6'd3, 5'd6, 6'd1);
        check_write("clr_run0", 6'd0, 6'd5, 5'd4);
        bus.clear_req = 1'b1;
        for (int i = 1; i < 10; i++) begin
            tick();
            bus.clear_req = 1'b0;
            check_write("clr_run", 6'(i), 6'd5, 5'd4);
            check_output("clr_run_busy", bus.clear_busy, 1);
        end
        tick();
        check_output("clr_gap", {bus.fb_we, bus.clear_busy, bus.req0_ready}, 3'b010);
        tick();
        for (int c = 0; c < 1200; c++) begin
            check_output("clr_cell", {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_char, bus.clear_busy, bus.req0_ready},
                         {1'b1, 6'(c % 40), 6'(c / 40), 5'd0, 1'b1, 1'b0});
            tick();
        end
        check_output("clr_done", {bus.fb_we, bus.clear_busy, bus.req0_ready}, 3'b001);
        tick();
        bus.req0_valid = 1'b0;
        check_write("clr_then_req0", 6'd3, 6'd3, 5'd6);
        tick();
        tick();

        // asynchronous reset in the middle of a clear
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_output("rst_clr_busy", {bus.clear_busy, bus.fb_we}, 2'b10);
        tick();
        for (int c = 0; c < 500; c++) tick();
        check_write("rst_cell500", 6'd20, 6'd12, 5'd0);
        #2 reset_n = 1'b0;
        #1 check_output("rst_async", {bus.fb_we, bus.clear_busy, bus.err}, 0);
        apply_stimulus(0, 1'b1, 6'd9, 6'd9, 5'd9, 6'd1);
        apply_stimulus(1, 1'b1, 6'd8, 6'd8, 5'd8, 6'd1);
        #1 reset_n = 1'b1;
        #1 check_output("rst_grant0", {bus.req0_ready, bus.req1_ready, bus.clear_busy}, 3'b100);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check_write("rst_req0_write", 6'd9, 6'd9, 5'd9);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
